// File: rtl/f_pc_sequencer_pkg.sv
// Shared decode codes, FSM state type and branch-offset helper for the fetch PC sequencer.
package pc_pkg;

  localparam logic [1:0] JUMP_BRANCH = 2'b00;
  localparam logic [1:0] JUMP_J      = 2'b01;
  localparam logic [1:0] JUMP_JR     = 2'b10;
  localparam logic [1:0] JUMP_SEQ    = 2'b11;

  localparam logic [1:0] BOP_NONE = 2'b00;
  localparam logic [1:0] BOP_BNE  = 2'b10;
  localparam logic [1:0] BOP_BEQ  = 2'b11;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    MISS = 2'd2
  } pc_state_e;

  // Sign-extended word offset, already scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/f_pc_sequencer_branch_resolve.sv
// Combinational control-transfer resolution: taken flag, target address and jr misalignment.
module f_branch_resolve
  import pc_pkg::*;
(
  input  logic        en_i,
  input  logic [1:0]  jump_i,
  input  logic [1:0]  bop_i,
  input  logic [31:0] pc4_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] index_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic        taken_o,
  output logic [31:0] target_o,
  output logic        misaligned_o
);

  logic operands_equal;

  always_comb begin
    operands_equal = (rs_i == rt_i);
    taken_o        = 1'b0;
    target_o       = pc4_i + branch_offset(imm_i);
    misaligned_o   = 1'b0;
    case (jump_i)
      JUMP_BRANCH: begin
        case (bop_i)
          BOP_BEQ:  taken_o = en_i & operands_equal;
          BOP_BNE:  taken_o = en_i & ~operands_equal;
          BOP_NONE: taken_o = 1'b0;
          default:  taken_o = 1'b0;
        endcase
      end
      JUMP_J: begin
        taken_o  = en_i;
        target_o = {pc4_i[31:28], index_i, 2'b00};
      end
      JUMP_JR: begin
        taken_o      = en_i;
        target_o     = {rs_i[31:2], 2'b00};
        misaligned_o = en_i & (rs_i[1:0] != 2'b00);
      end
      JUMP_SEQ: taken_o = 1'b0;
      default:  taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/f_pc_sequencer.sv
// Fetch-stage PC sequencer: PC register, imem request, IF/ID register and redirect handling.
// Optional BRANCH_DELAY_SLOT_EN keeps the redirect-cycle fetch as a valid delay slot.
module f_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic [1:0]  i_con_jump,
  input  logic [1:0]  i_con_bop,
  input  logic        i_d_valid,
  input  logic [31:0] i_d_pc4,
  input  logic [15:0] i_d_imm,
  input  logic [25:0] i_d_index,
  input  logic [31:0] i_d_rs_data,
  input  logic [31:0] i_d_rt_data,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_ready,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_req,
  output logic [31:0] o_d_instr,
  output logic [31:0] o_d_pc4,
  output logic        o_d_valid,
  output logic        o_redirect,
  output logic        o_misaligned
);
  import pc_pkg::*;

  pc_state_e   state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;
  logic        req_q;

  logic        taken;
  logic [31:0] target;
  logic        misaligned;
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + 32'd4;

  f_branch_resolve u_resolve (
    .en_i         (i_d_valid & ~i_stall),
    .jump_i       (i_con_jump),
    .bop_i        (i_con_bop),
    .pc4_i        (i_d_pc4),
    .imm_i        (i_d_imm),
    .index_i      (i_d_index),
    .rs_i         (i_d_rs_data),
    .rt_i         (i_d_rt_data),
    .taken_o      (taken),
    .target_o     (target),
    .misaligned_o (misaligned)
  );

`ifdef BRANCH_DELAY_SLOT_EN
  logic        pend_v_q;
  logic [31:0] pend_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_v_q <= 1'b0;
      pend_q   <= '0;
`endif
    end else if (!i_stall) begin
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          req_q   <= 1'b1;
          if (taken) pc_q <= target;
        end
        RUN, MISS: begin
`ifdef BRANCH_DELAY_SLOT_EN
          // The redirect-cycle fetch is the delay slot; a missed delay slot
          // parks the target until the slot has been delivered.
          if (i_imem_ready) begin
            instr_q  <= i_imem_rdata;
            pc4_q    <= pc_inc;
            valid_q  <= 1'b1;
            state_q  <= RUN;
            pend_v_q <= 1'b0;
            if (taken)         pc_q <= target;
            else if (pend_v_q) pc_q <= pend_q;
            else               pc_q <= pc_inc;
          end else begin
            valid_q <= 1'b0;
            state_q <= MISS;
            if (taken) begin
              pend_q   <= target;
              pend_v_q <= 1'b1;
            end
          end
`else
          if (taken) begin
            pc_q    <= target;
            valid_q <= 1'b0;
            state_q <= (state_q == RUN && i_imem_ready) ? RUN : MISS;
          end else if (i_imem_ready) begin
            instr_q <= i_imem_rdata;
            pc4_q   <= pc_inc;
            valid_q <= 1'b1;
            pc_q    <= pc_inc;
            state_q <= RUN;
          end else begin
            valid_q <= 1'b0;
            state_q <= MISS;
          end
`endif
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign o_imem_addr  = pc_q;
  assign o_imem_req   = req_q;
  assign o_d_instr    = instr_q;
  assign o_d_pc4      = pc4_q;
  assign o_d_valid    = valid_q;
  assign o_redirect   = taken;
  assign o_misaligned = misaligned;

endmodule

// File: tb/tb_f_pc_sequencer.sv
// Self-checking bench for f_pc_sequencer (default build): directed steps then random traffic.
module tb_f_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [1:0]  con_jump;
  logic [1:0]  con_bop;
  logic        d_valid;
  logic [31:0] d_pc4;
  logic [15:0] d_imm;
  logic [25:0] d_index;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] q_instr;
  logic [31:0] q_pc4;
  logic        q_valid;
  logic        redirect;
  logic        misaligned;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model of architecturally visible state.
  bit          m_booted;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  bit          m_valid;

  always #5 clk = ~clk;

  f_pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_stall      (stall),
    .i_con_jump   (con_jump),
    .i_con_bop    (con_bop),
    .i_d_valid    (d_valid),
    .i_d_pc4      (d_pc4),
    .i_d_imm      (d_imm),
    .i_d_index    (d_index),
    .i_d_rs_data  (rs_data),
    .i_d_rt_data  (rt_data),
    .i_imem_rdata (imem_rdata),
    .i_imem_ready (imem_ready),
    .o_imem_addr  (imem_addr),
    .o_imem_req   (imem_req),
    .o_d_instr    (q_instr),
    .o_d_pc4      (q_pc4),
    .o_d_valid    (q_valid),
    .o_redirect   (redirect),
    .o_misaligned (misaligned)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_booted = 0;
    m_pc     = RST_PC;
    m_instr  = '0;
    m_pc4    = '0;
    m_valid  = 0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_addr"},  imem_addr, RST_PC);
    chk({tag, "_req"},   32'(imem_req), 32'd0);
    chk({tag, "_valid"}, 32'(q_valid), 32'd0);
    chk({tag, "_instr"}, q_instr, 32'd0);
    chk({tag, "_pc4"},   q_pc4, 32'd0);
  endtask

  // One cycle: drive inputs just after a negedge, check, advance model, wait to next negedge.
  task automatic step(input logic s, input logic rdy, input logic dv,
                      input logic [1:0] jmp, input logic [1:0] bop,
                      input logic [31:0] pc4, input logic [15:0] imm,
                      input logic [25:0] idx, input logic [31:0] rs, input logic [31:0] rt);
    bit          tk;
    bit          mis;
    logic [31:0] tgt;
    int          off;
    stall = s; imem_ready = rdy; d_valid = dv; con_jump = jmp; con_bop = bop;
    d_pc4 = pc4; d_imm = imm; d_index = idx; rs_data = rs; rt_data = rt;
    #1;
    tk = 0; mis = 0; tgt = '0;
    off = int'($signed(imm));
    if (dv && !s) begin
      if (jmp == 2'd1) begin
        tk  = 1;
        tgt = (pc4 & 32'hF000_0000) + 32'(idx) * 4;
      end else if (jmp == 2'd2) begin
        tk  = 1;
        tgt = rs - (rs % 4);
        mis = (rs % 4) != 0;
      end else if (jmp == 2'd0) begin
        tgt = pc4 + 32'(off * 4);
        if (bop == 2'd3) tk = (rs == rt);
        if (bop == 2'd2) tk = (rs != rt);
      end
    end
    chk("imem_addr",  imem_addr, m_pc);
    chk("imem_req",   32'(imem_req), 32'(m_booted));
    chk("d_valid",    32'(q_valid), 32'(m_valid));
    if (m_valid) begin
      chk("d_instr", q_instr, m_instr);
      chk("d_pc4",   q_pc4, m_pc4);
    end
    chk("redirect",   32'(redirect), 32'(tk));
    chk("misaligned", 32'(misaligned), 32'(mis));
    if (!s) begin
      if (tk) begin
        m_pc     = tgt;
        m_valid  = 0;
        m_booted = 1;
      end else if (!m_booted) begin
        m_booted = 1;
      end else if (rdy) begin
        m_instr = mem_word(m_pc);
        m_pc4   = m_pc + 32'd4;
        m_pc    = m_pc + 32'd4;
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, rdy, 1'b0, 2'b11, 2'b00, '0, '0, '0, '0, '0);
  endtask

  logic [31:0] held_pc;

  initial begin
    rst_n = 1'b0;
    stall = 0; con_jump = 2'b11; con_bop = 0; d_valid = 0; d_pc4 = 0;
    d_imm = 0; d_index = 0; rs_data = 0; rt_data = 0; imem_ready = 1;
    model_reset();
    @(negedge clk);
    #1;
    chk_reset_values("reset");
    chk("reset_redirect", 32'(redirect), 32'd0);
    rst_n = 1'b1;

    // Boot and sequential fetch
    idle(1'b1);
    idle(1'b1);
    chk("seq_addr1", imem_addr, 32'h0040_0004);
    chk("seq_valid1", 32'(q_valid), 32'd1);
    idle(1'b1);
    chk("seq_addr2", imem_addr, 32'h0040_0008);

    // beq taken, backward offset
    step(1'b0, 1'b1, 1'b1, 2'b00, 2'b11, 32'h100, 16'hFFFE, '0, 32'd5, 32'd5);
    chk("beq_target", imem_addr, 32'h0000_00F8);
    chk("beq_bubble", 32'(q_valid), 32'd0);
    idle(1'b1);
    idle(1'b1);

    // jr misaligned
    step(1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 32'h44, '0, '0, 32'h2003, '0);
    chk("jr_target", imem_addr, 32'h0000_2000);

    // imem miss for three cycles
    idle(1'b1);
    held_pc = m_pc;
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("miss_hold", imem_addr, held_pc);
    idle(1'b1);
    chk("miss_deliver", q_instr, mem_word(held_pc));

    // stall over a taken bne, then release
    held_pc = m_pc;
    step(1'b1, 1'b1, 1'b1, 2'b00, 2'b10, 32'h800, 16'h0010, '0, 32'd1, 32'd2);
    chk("stall_hold", imem_addr, held_pc);
    step(1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 32'h800, 16'h0010, '0, 32'd1, 32'd2);
    chk("bne_target", imem_addr, 32'h0000_0840);

    // j/jal keeps upper PC bits
    step(1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 32'hA000_0010, '0, 26'h0123456, '0, '0);
    chk("j_target", imem_addr, 32'hA048_D158);

    // PC wrap at the top of the address space
    step(1'b0, 1'b1, 1'b1, 2'b10, 2'b00, '0, '0, '0, 32'hFFFF_FFFC, '0);
    idle(1'b1);
    chk("wrap_pc", imem_addr, 32'h0000_0000);
    chk("wrap_pc4", q_pc4, 32'h0000_0000);

    // asynchronous reset in mid-run
    idle(1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_values("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] rs;
      logic [31:0] rt;
      rs = $urandom;
      if ($urandom_range(0, 3) == 0) rs[1:0] = 2'($urandom_range(1, 3));
      rt = ($urandom_range(0, 1) == 0) ? rs : 32'($urandom);
      step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) != 0), 2'($urandom), 2'($urandom),
           32'($urandom), 16'($urandom), 26'($urandom), rs, rt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
